// File: rtl/render_scheduler.sv
// render_scheduler: frame job sequencer with per-job watchdog and pixel-port arbiter
module render_scheduler #(
  parameter int SCREEN_X = 640,
  parameter int SCREEN_Y = 480,
  parameter int TIMEOUT = 4096,
  localparam int XW = $clog2(SCREEN_X) + 1,
  localparam int YW = $clog2(SCREEN_Y) + 1,
  localparam int TW = $clog2(TIMEOUT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          frameTick,
  input  logic          clear_err,
  output logic          pulse_clear1,
  output logic          pulse_draw1,
  output logic          pulse_clear2,
  output logic          pulse_draw2,
  input  logic          done_clear1,
  input  logic          done_draw1,
  input  logic          done_clear2,
  input  logic          done_draw2,
  output logic          pulse_ball_clear,
  output logic          pulse_ball_draw,
  input  logic          done_ball_clear,
  input  logic          done_ball_draw,
  input  logic [XW-1:0] paddle_x,
  input  logic [YW-1:0] paddle_y,
  input  logic [2:0]    paddle_col,
  input  logic [XW-1:0] ball_x,
  input  logic [YW-1:0] ball_y,
  input  logic [2:0]    ball_col,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [2:0]    vga_col,
  output logic          plot,
  output logic [2:0]    job,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] job_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [5:0] done_v, pulse_v;
  logic hit, expire, adv, last, start;
  assign done_v = {done_ball_draw, done_ball_clear, done_draw2, done_clear2, done_draw1, done_clear1};
  assign pulse_v = (enable && state == PULSE) ? 6'(1) << job : '0;
  assign {pulse_ball_draw, pulse_ball_clear, pulse_draw2, pulse_clear2, pulse_draw1, pulse_clear1} = pulse_v;
  assign busy = state != IDLE || frame_done;
  // a tick landing on the frame_done cycle is treated as an overrun, not a new frame
  always_comb begin
    hit = state == WAIT && done_v[job];
    expire = state == WAIT && !hit && timer == TW'(TIMEOUT - 1);
    adv = hit || expire;
    last = job == 3'd5;
    start = state == IDLE && frameTick && !frame_done;
    state_nx = !enable ? state :
               state == IDLE ? (start ? PULSE : IDLE) :
               state == PULSE ? WAIT :
               adv ? (last ? IDLE : PULSE) : WAIT;
    job_nx = !enable ? job : start ? 3'd0 : (adv && !last) ? job + 3'd1 : job;
    timer_nx = !enable ? timer : state == PULSE ? '0 :
               (state == WAIT && !adv && timer != '1) ? timer + 1'b1 : timer;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      job <= '0;
      timer <= '0;
      frame_done <= 1'b0;
      plot <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_col <= '0;
    end else begin
      state <= state_nx;
      job <= job_nx;
      timer <= timer_nx;
      frame_done <= enable && adv && last;
      plot <= enable && state == WAIT;
      overrun <= (overrun && !clear_err) || (enable && frameTick && busy);
      timeout_err <= (timeout_err && !clear_err) || (enable && expire);
      if (enable) begin
        vga_x <= job < 3'd4 ? paddle_x : ball_x;
        vga_y <= job < 3'd4 ? paddle_y : ball_y;
        vga_col <= job < 3'd4 ? paddle_col : ball_col;
      end
    end
  end
endmodule
